// File: rtl/cacheline_burst_adapter.sv
// Bridges single-cycle cache line requests to four-beat memory bursts.
// Read beats are assembled into line_o and write beats are streamed out of a latched buffer.
module cacheline_burst_adapter #(
    parameter int s_offset = 5,
    parameter int burst_w  = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [(8<<s_offset)-1:0]    line_i,
    output logic [(8<<s_offset)-1:0]    line_o,
    input  logic [31:0]                 address_i,
    input  logic                        read_i,
    input  logic                        write_i,
    output logic                        resp_o,
    input  logic [burst_w-1:0]          burst_i,
    output logic [burst_w-1:0]          burst_o,
    output logic [31:0]                 address_o,
    output logic                        read_o,
    output logic                        write_o,
    input  logic                        resp_i
);

    localparam int LINE_W = 8 << s_offset;
    localparam int BEATS  = LINE_W / burst_w;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [LINE_W-1:0] wbuf_q, wbuf_d;
    logic [LINE_W-1:0] line_q, line_d;

    // Offset bits of the request address never reach memory; the burst is line aligned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address_i[s_offset-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wbuf_d  = wbuf_q;
        line_d  = line_q;
        case (state_q)
            ST_IDLE: begin
                if (read_i || write_i) begin
                    state_d = read_i ? ST_READ : ST_WRITE;
                    addr_d  = {address_i[31:s_offset], {s_offset{1'b0}}};
                    wbuf_d  = line_i;
                    cnt_d   = '0;
                end
            end
            ST_READ: begin
                if (resp_i) begin
                    line_d[int'(cnt_q)*burst_w +: burst_w] = burst_i;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_WRITE: begin
                if (resp_i) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wbuf_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wbuf_q  <= wbuf_d;
            line_q  <= line_d;
        end
    end

    // Memory-side strobes depend only on registered state, never on the cache request.
    always_comb begin
        read_o    = (state_q == ST_READ);
        write_o   = (state_q == ST_WRITE);
        resp_o    = (state_q == ST_DONE);
        address_o = addr_q;
        line_o    = line_q;
        burst_o   = '0;
        if (state_q == ST_WRITE) begin
            burst_o = wbuf_q[int'(cnt_q)*burst_w +: burst_w];
        end
    end

endmodule
